seg7_scan_driver: RTL and testbench

Multiplexed, parametrised seven-segment display driver. It holds a DIGITS-wide hex value with per-digit decimal point, blank and blink controls, and scans the digits one at a time onto a shared segment bus with one-hot digit enables. New display values are accepted through a valid/ready load port and committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the numeric/status logic and the board display pins, replacing single-digit combinational decoding at the top level.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_scan_driver_if.sv | 21 ++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/seg7_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg7_pkg;

  // Bit positions of segments a..g on the segment bus.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high hex glyphs, bit SEG_A is segment a.
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;  // abcdef
  localparam logic [6:0] SEG_HEX_1 = 7'h06;  // bc
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;  // abdeg
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;  // abcdg
  localparam logic [6:0] SEG_HEX_4 = 7'h66;  // bcfg
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;  // acdfg
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;  // acdefg
  localparam logic [6:0] SEG_HEX_7 = 7'h07;  // abc
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;  // abcdefg
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;  // abcdfg
  localparam logic [6:0] SEG_HEX_A = 7'h77;  // abcefg
  localparam logic [6:0] SEG_HEX_B = 7'h7C;  // cdefg
  localparam logic [6:0] SEG_HEX_C = 7'h39;  // adef
  localparam logic [6:0] SEG_HEX_D = 7'h5E;  // bcdeg
  localparam logic [6:0] SEG_HEX_E = 7'h79;  // adefg
  localparam logic [6:0] SEG_HEX_F = 7'h71;  // aefg

  // Wide enough to address up to 16 digits.
  typedef logic [3:0] digit_idx_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load handshake between the value producer and the scan driver.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;
  logic [DIGITS-1:0]     load_dp;
  logic [DIGITS-1:0]     load_blank;
  logic [DIGITS-1:0]     load_blink;

  modport master (
    output load_valid, load_data, load_dp, load_blank, load_blink,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_data, load_dp, load_blank, load_blink,
    output load_ready
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high a..g glyph decode.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Glyph lookup.
  always_comb begin
    seg = SEG_HEX_0;
    case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      default: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous value commit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  seg7_scan_driver_if.slave    ld,
  output logic [6:0]           seg,
  output logic                 seg_dp,
  output logic [DIGITS-1:0]    an,
  output logic                 frame_tick
);

  localparam int   DIV_W = $clog2(SCAN_DIV);
  localparam int   FC_W  = $clog2(BLINK_FRAMES + 1);
  localparam logic INV   = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]    div;
  digit_idx_t          digit;
  logic [FC_W-1:0]     frame_cnt;
  logic                blink_phase;  // 1 = dark half of the blink period

  logic                pending_valid;
  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic [DIGITS-1:0]   pend_blank, act_blank;
  logic [DIGITS-1:0]   pend_blink, act_blink;

  logic                last_div, last_digit, boundary, accept;
  logic [3:0]          sel_nib;
  logic                sel_dp, sel_blank, sel_blink, lit;
  logic [DIGITS-1:0]   sel_onehot;
  logic [6:0]          glyph;

  assign last_div      = (div == DIV_W'(SCAN_DIV - 1));
  assign last_digit    = (digit == digit_idx_t'(DIGITS - 1));
  assign boundary      = last_div && last_digit;
  // Ready is low while a value waits, so accept and commit never collide.
  assign accept        = ld.load_valid && !pending_valid;
  assign ld.load_ready = !pending_valid;

  // Slot and digit position counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div   <= '0;
      digit <= '0;
    end else if (last_div) begin
      div   <= '0;
      digit <= last_digit ? '0 : digit + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Blink half-period counted in whole frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Double-buffered display value: capture on accept, publish at frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pend_data     <= '0;
      pend_dp       <= '0;
      pend_blank    <= '0;
      pend_blink    <= '0;
      act_data      <= '0;
      act_dp        <= '0;
      act_blank     <= '1;
      act_blink     <= '0;
    end else if (accept) begin
      pending_valid <= 1'b1;
      pend_data     <= ld.load_data;
      pend_dp       <= ld.load_dp;
      pend_blank    <= ld.load_blank;
      pend_blink    <= ld.load_blink;
    end else if (boundary && pending_valid) begin
      pending_valid <= 1'b0;
      act_data      <= pend_data;
      act_dp        <= pend_dp;
      act_blank     <= pend_blank;
      act_blink     <= pend_blink;
    end
  end

  // Select the fields of the digit currently being scanned.
  always_comb begin
    sel_nib    = '0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b1;
    sel_blink  = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit == digit_idx_t'(i)) begin
        sel_nib       = act_data[4*i +: 4];
        sel_dp        = act_dp[i];
        sel_blank     = act_blank[i];
        sel_blink     = act_blink[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nib (sel_nib),
    .seg (glyph)
  );

  // First cycle of each slot stays dark to hide ghosting between digits.
  assign lit = (div != '0) && !(sel_blank || (blink_phase && sel_blink));

  // Registered pin drive with polarity applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg        <= {7{INV}};
      seg_dp     <= INV;
      an         <= {DIGITS{INV}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= {7{INV}} ^ (lit ? glyph : 7'h00);
      seg_dp     <= INV ^ (lit && sel_dp);
      an         <= {DIGITS{INV}} ^ (lit ? sel_onehot : '0);
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a frame-arithmetic model predicts every output cycle.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = D * SD;

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [D-1:0] an;
    logic         ft;
    logic         rdy;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic           lv = 1'b0;
  logic [4*D-1:0] ldata = '0;
  logic [D-1:0]   ldp = '0, lblank = '0, lblink = '0;

  logic [6:0]   seg_a, seg_b;
  logic         dp_a, dp_b, ft_a, ft_b;
  logic [D-1:0] an_a, an_b;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  seg7_scan_driver_if #(.DIGITS(D)) ifa ();
  seg7_scan_driver_if #(.DIGITS(D)) ifb ();

  assign ifa.load_valid = lv;    assign ifb.load_valid = lv;
  assign ifa.load_data  = ldata; assign ifb.load_data  = ldata;
  assign ifa.load_dp    = ldp;   assign ifb.load_dp    = ldp;
  assign ifa.load_blank = lblank; assign ifb.load_blank = lblank;
  assign ifa.load_blink = lblink; assign ifb.load_blink = lblink;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset), .ld(ifa),
    .seg(seg_a), .seg_dp(dp_a), .an(an_a), .frame_tick(ft_a)
  );

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset), .ld(ifb),
    .seg(seg_b), .seg_dp(dp_b), .an(an_b), .frame_tick(ft_b)
  );

  always #5 clk = ~clk;

  // Glyphs written as the list of lit segment letters.
  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    string pats[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    string s;
    logic [6:0] r;
    r = '0;
    s = pats[n];
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  // Reference model: position in frame and blink phase derived from the cycle count.
  initial begin
    int k, pos, dv, dg, fr;
    bit pend, bnd, dark, lit;
    logic [4*D-1:0] p_data, a_data;
    logic [D-1:0] p_dp, p_blank, p_blink, a_dp, a_blank, a_blink;
    exp_t e;
    k = 0; pend = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        k = 0; pend = 0;
        a_data = '0; a_dp = '0; a_blank = '1; a_blink = '0;
      end else begin
        pos  = k % FR;
        dv   = pos % SD;
        dg   = pos / SD;
        fr   = k / FR;
        bnd  = (pos == FR - 1);
        dark = a_blank[dg] || (((fr / BF) % 2 == 1) && a_blink[dg]);
        lit  = (dv != 0) && !dark;
        e.seg = lit ? glyph_of(a_data[dg*4 +: 4]) : 7'h00;
        e.dp  = lit && a_dp[dg];
        e.an  = lit ? D'(1 << dg) : '0;
        e.ft  = bnd;
        if (lv && !pend) begin
          pend = 1; p_data = ldata; p_dp = ldp; p_blank = lblank; p_blink = lblink;
        end else if (bnd && pend) begin
          pend = 0; a_data = p_data; a_dp = p_dp; a_blank = p_blank; a_blink = p_blink;
        end
        e.rdy = !pend;
        q.push_back(e);
        k++;
      end
    end
  end

  // Monitor: compare both polarities every cycle, away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        checks++;
        if (seg_a !== 7'h7F || dp_a !== 1'b1 || an_a !== 4'hF || ft_a !== 1'b0 || ifa.load_ready !== 1'b1 ||
            seg_b !== 7'h00 || dp_b !== 1'b0 || an_b !== 4'h0 || ft_b !== 1'b0 || ifb.load_ready !== 1'b1) begin
          errors++;
          $display("FAIL reset_state t=%0t got a:seg=%h dp=%b an=%h ft=%b rdy=%b b:seg=%h dp=%b an=%h ft=%b exp a:7f/1/f/0/1 b:00/0/0/0",
                   $time, seg_a, dp_a, an_a, ft_a, ifa.load_ready, seg_b, dp_b, an_b, ft_b);
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (seg_a !== ~e.seg || dp_a !== ~e.dp || an_a !== ~e.an || ft_a !== e.ft || ifa.load_ready !== e.rdy) begin
          errors++;
          $display("FAIL scan_low t=%0t got seg=%h dp=%b an=%h ft=%b rdy=%b exp seg=%h dp=%b an=%h ft=%b rdy=%b",
                   $time, seg_a, dp_a, an_a, ft_a, ifa.load_ready, ~e.seg, ~e.dp, ~e.an, e.ft, e.rdy);
        end
        checks++;
        if (seg_b !== e.seg || dp_b !== e.dp || an_b !== e.an || ft_b !== e.ft || ifb.load_ready !== e.rdy) begin
          errors++;
          $display("FAIL scan_high t=%0t got seg=%h dp=%b an=%h ft=%b rdy=%b exp seg=%h dp=%b an=%h ft=%b rdy=%b",
                   $time, seg_b, dp_b, an_b, ft_b, ifb.load_ready, e.seg, e.dp, e.an, e.ft, e.rdy);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one value and hold it until accepted; scramble the inputs afterwards.
  task automatic do_load(input logic [4*D-1:0] d, input logic [D-1:0] p, input logic [D-1:0] b,
                         input logic [D-1:0] k);
    bit acc, done;
    done = 0;
    lv = 1'b1; ldata = d; ldp = p; lblank = b; lblink = k;
    for (int n = 0; n < 200 && !done; n++) begin
      acc = ifa.load_ready;
      @(posedge clk); #1;
      if (acc) done = 1;
    end
    lv = 1'b0;
    ldata = 16'($urandom); ldp = 4'($urandom); lblank = 4'($urandom); lblink = 4'($urandom);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL load_accept got no accept in 200 cycles exp accept for data=%h", d);
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = ft_a;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_tick_wait got no pulse in 100 cycles exp pulse every %0d", FR);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(40);

    // Load and scan.
    do_load(16'h8310, 4'b0100, 4'b0000, 4'b0000);
    tick(3 * FR);

    // Tearing: second load waits for the first to commit.
    do_load(16'h1111, '0, '0, '0);
    tick(6);
    do_load(16'h2222, '0, '0, '0);
    tick(3 * FR);

    // Back-pressure with data changing every cycle.
    lv = 1'b1;
    repeat (8 * FR) begin
      ldata = 16'($urandom); ldp = 4'($urandom); lblank = 4'($urandom & 1); lblink = 4'($urandom);
      tick(1);
    end
    lv = 1'b0;
    tick(2 * FR);

    // Blank / blink.
    do_load(16'($urandom), 4'b1111, 4'b0001, 4'b0010);
    tick(10 * FR);

    // Random traffic.
    for (int i = 0; i < 20; i++) begin
      do_load(16'($urandom), 4'($urandom), 4'($urandom & 5), 4'($urandom));
      tick($urandom_range(0, 2 * FR));
    end

    // Reset with a value pending.
    wait_frame();
    do_load(16'hABCD, 4'b1111, 4'b0000, 4'b0000);
    tick(2);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
